// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry, line levels
// and the parity helper used by the receiver (and later by uart_tx).
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Even-parity bit for a data byte: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial lines, buttons);
// synchronous active-low reset forces both flops to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames on rx_i to bytes on a valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err_o pulse output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s;
  logic [BIT_W-1:0]     bit_r, bit_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 byte_done_s;
  logic                 frame_err_s;

  logic [7:0]           data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;
  logic                 accept_s;

`ifdef UART_RX_PARITY_EN
  logic                 parity_r, parity_next_s;
  logic                 parity_err_r;
`endif

  sync2 #(.RST_VAL(IDLE_LEVEL)) u_rx_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  // Frame state, bit timing counter, bit index and shift register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bit_r    <= '0;
      shift_r  <= '0;
`ifdef UART_RX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      bit_r    <= bit_next_s;
      shift_r  <= shift_next_s;
`ifdef UART_RX_PARITY_EN
      parity_r <= parity_next_s;
`endif
    end
  end

  // Next-state logic; every sample point is a counter wrap at mid-bit.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    bit_next_s    = bit_r;
    shift_next_s  = shift_r;
    byte_done_s   = 1'b0;
    frame_err_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (rx_s == START_LEVEL) begin
          state_next_s = START;
          cnt_next_s   = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF_LAST) begin
          cnt_next_s = '0;
          bit_next_s = '0;
          if (rx_s == START_LEVEL) begin
            state_next_s = DATA;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_next_s   = '0;
          shift_next_s = {rx_s, shift_r[DATA_BITS-1:1]};
          if (bit_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = PARITY;
`else
            state_next_s = STOP;
`endif
          end else begin
            bit_next_s = bit_r + BIT_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_next_s    = '0;
          parity_next_s = rx_s;
          state_next_s  = STOP;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_r == CNT_BIT_LAST) begin
          cnt_next_s = '0;
          if (rx_s == IDLE_LEVEL) begin
            byte_done_s  = 1'b1;
            state_next_s = IDLE;
          end else begin
            frame_err_s  = 1'b1;
            state_next_s = WAIT_IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s == IDLE_LEVEL) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // A completed byte may load when the holding register is empty or draining now.
  assign accept_s = byte_done_s && (!valid_r || ready_i);

  // Holding register, handshake and one-cycle status pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      frame_err_r  <= frame_err_s;
      overrun_r    <= byte_done_s && valid_r && !ready_i;
      busy_r       <= (state_next_s != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_err_r <= byte_done_s && (even_parity(shift_r) != parity_r);
`endif
    end
  end

  assign data_o       = data_r;
  assign valid_o      = valid_r;
  assign frame_err_o  = frame_err_r;
  assign overrun_o    = overrun_r;
  assign busy_o       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; expected bytes are queued
// by the stimulus and checked by a monitor at each valid/ready handshake.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int vcyc = 0, fe_n = 0, ov_n = 0, pe_n = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  // Monitor: count pulses and check each handshaked byte against the queue.
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (valid_o) vcyc++;
      if (frame_err_o) fe_n++;
      if (overrun_o) ov_n++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) pe_n++;
`endif
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_byte: got %h expected none", data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            n_bad++;
            $display("FAIL byte: got %h expected %h", data_o, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int v0, f0, o0, p0;
    rst_n_i = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n_i = 1'b1;
    repeat (20) @(negedge clk);

    // Plain byte with ready held high
    v0 = vcyc; f0 = fe_n; o0 = ov_n;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    wait_drain("a5_drain");
    check("a5_valid_cycles", vcyc - v0, 1);
    check("a5_ferr", fe_n - f0, 0);
    check("a5_ovr", ov_n - o0, 0);

    // False start: 5-clock glitch low
    v0 = vcyc; f0 = fe_n;
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    rx_i = 1'b1;
    repeat (30) @(negedge clk);
    check("fs_busy", busy_o, 0);
    check("fs_valid", vcyc - v0, 0);
    check("fs_ferr", fe_n - f0, 0);

    // Stop bit low, line held low a while, then released
    v0 = vcyc; f0 = fe_n;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    check("fe_busy_low", busy_o, 1);
    rx_i = 1'b1;
    repeat (10) @(negedge clk);
    check("fe_pulses", fe_n - f0, 1);
    check("fe_valid", vcyc - v0, 0);
    check("fe_busy_clear", busy_o, 0);

    // Overrun: ready low, two back-to-back bytes
    ready_i = 1'b0;
    o0 = ov_n;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_valid", valid_o, 1);
    check("ovr_data", data_o, 8'h11);
    check("ovr_pulses", ov_n - o0, 1);
    ready_i = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_valid_clr", valid_o, 0);
    check("ovr_data_keep", data_o, 8'h11);

    // Reset during bit 4 of 0xFF
    f0 = fe_n; o0 = ov_n;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(negedge clk);
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ferr", frame_err_o, 0);
    check("mid_rst_ovr", overrun_o, 0);
    rst_n_i = 1'b1;
    repeat (80) @(negedge clk);
    check("post_rst_ferr", fe_n - f0, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    wait_drain("r42_drain");
    check("post_rst_ovr", ov_n - o0, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte still delivered, one parity pulse
    p0 = pe_n;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    wait_drain("par_drain");
    check("par_pulses", pe_n - p0, 1);
`else
    p0 = pe_n;
    check("par_none", pe_n - p0, 0);
`endif

    check("q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 serial frames on rx_i in, parallel bytes out through a valid/ready holding register.
- Counterpart to the board's existing tx_o serial path; runs on the 25 MHz board clock.
- Connects the serial pin to downstream logic, e.g. an LED/command decoder.

Parameters:
- CLK_HZ, 25000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- Derived localparams (not overridable):
  - CLKS_PER_BIT = CLK_HZ/BAUD, integer division, 217 at defaults; must be ≥ 4.
  - HALF_BIT = CLKS_PER_BIT/2.
  - Counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset; one clock, reset is synchronous and active-low
- rx_i  input  1  asynchronous serial line, idle high
- data_o  output  8  received byte, valid while valid_o=1
- valid_o  output  1  byte available in holding register
- ready_i  input  1  consumer accepts byte when valid_o&&ready_i
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: byte completed while holding register full
- busy_o  output  1  state != IDLE

Behaviour:
- Reset: while rst_n_i=0 at a clk_i edge:
  - state=IDLE; counters=0.
  - data_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Synchronizer flops=1.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- rx_i passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value rx_s; 2-cycle input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_s=0, go to START with bit counter cleared.
- START: count to HALF_BIT-1, then sample rx_s.
  - 0: go to DATA, bit index 0, counter cleared.
  - 1: false start, return to IDLE; no error.
- DATA: sample every CLKS_PER_BIT clocks (mid-bit), LSB first, into a shift register. After bit 7, go to STOP.
- STOP: sample after CLKS_PER_BIT clocks.
  - rx_s=1: byte complete, go to IDLE.
  - rx_s=0: frame_err_o pulses for 1 cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then IDLE. A line held low (break) therefore yields exactly one frame_err.
- Byte complete:
  - Holding register empty, or being emptied in the same cycle (valid_o&&ready_i): data_o loads and valid_o=1 on the next cycle.
  - Holding register full and not emptying: overrun_o pulses for 1 cycle, new byte dropped, data_o unchanged.
- Handshake:
  - valid_o stays high and data_o stays stable until valid_o&&ready_i; valid_o then clears next cycle unless reloaded that same cycle.
  - ready_i is ignored while valid_o=0.
- Latency: valid_o rises 1 clk after the stop-bit mid-sample, about 9.5 bit times plus 3 clks after the rx_i falling edge.
- Next start bit is detected from IDLE, so back-to-back frames are accepted with no idle gap.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows bit 7, sampled mid-bit in a PARITY state between DATA and STOP.
  - Extra output parity_err_o (1 bit, reset 0) pulses 1 cycle at byte completion if the XOR of data and parity is 1.
  - A byte with a parity error is still delivered. A frame error takes precedence: the byte is dropped and no parity pulse is emitted.
- Undefined: no PARITY state, no parity_err_o port, 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - DATA_BITS=8;
  - the IDLE_LEVEL=1'b1 and START_LEVEL=1'b0 constants, shared with the future uart_tx.
- One sub-module: sync2, a 2-flop synchronizer with synchronous active-low reset and a parameterized reset value. It is reused for other async inputs such as buttons.

Test Plan:
- CLK_HZ=16, BAUD=1 (CLKS_PER_BIT=16), ready_i=1, send 0xA5 8N1 -> data_o=8'hA5 with one valid_o cycle, frame_err_o=0, overrun_o=0.
- Same setup, pulse rx_i low for 5 clks -> false start, state back to IDLE, no valid_o, no frame_err_o.
- Send 0x3C with the stop bit held low, then idle -> exactly one frame_err_o pulse, no valid_o, busy_o clears after the line returns high.
- ready_i=0, send 0x11 then 0x22 back-to-back -> valid_o=1 with data_o=8'h11; one overrun_o pulse at the second stop; then ready_i=1 -> valid_o clears, data_o remains 8'h11.
- Assert rst_n_i=0 during bit 4 of 0xFF, release it, send 0x42 -> only 0x42 delivered, all outputs 0 during reset.
- With UART_RX_PARITY_EN, send 0x07 with parity=0 (wrong) -> data_o=8'h07, valid_o=1, parity_err_o pulses once.
